// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: data/load from board logic, pins back.
interface seg7_scan_driver_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] value;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   blank_in;
    logic                  load;
    logic [6:0]            seg;
    logic                  dp;
    logic [N_DIGITS-1:0]   an;
    logic                  frame_done;

    modport master (output value, dp_in, blank_in, load,
                    input  seg, dp, an, frame_done);
    modport slave  (input  value, dp_in, blank_in, load,
                    output seg, dp, an, frame_done);
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex 7-segment driver with frame-synchronous double buffering.
// Optional leading-zero suppression when SEG_LZ_BLANK_EN is defined.
module seg7_digit_lane (
    input  logic [3:0] nib,
    input  logic       dp_bit,
    input  logic       blank,
    input  logic       supp,
    output logic [6:0] seg,
    output logic       dp
);
    logic [6:0] dec;

    always_comb begin
        dec = 7'h00;
        case (nib)
            4'h0: dec = 7'h3F;
            4'h1: dec = 7'h06;
            4'h2: dec = 7'h5B;
            4'h3: dec = 7'h4F;
            4'h4: dec = 7'h66;
            4'h5: dec = 7'h6D;
            4'h6: dec = 7'h7D;
            4'h7: dec = 7'h07;
            4'h8: dec = 7'h7F;
            4'h9: dec = 7'h67;
            4'hA: dec = 7'h77;
            4'hB: dec = 7'h7C;
            4'hC: dec = 7'h39;
            4'hD: dec = 7'h5E;
            4'hE: dec = 7'h79;
            4'hF: dec = 7'h71;
            default: dec = 7'h00;
        endcase
    end

    // Suppression darkens segments only; the decimal point obeys blank alone.
    assign seg = (blank | supp) ? 7'h00 : dec;
    assign dp  = blank ? 1'b0 : dp_bit;
endmodule

module seg7_scan_driver #(
    parameter int N_DIGITS       = 4,
    parameter int SCAN_DIV       = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input logic           clk,
    input logic           rst,
    seg7_scan_driver_if.slave bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [6:0]          SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{AN_ACTIVE_LOW}};

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          tick, last, wrap;

    logic [N_DIGITS-1:0][3:0] sh_val, act_val;
    logic [N_DIGITS-1:0]      sh_dp, act_dp, sh_blank, act_blank;
    logic                     pending;

    logic [N_DIGITS-1:0][6:0] lane_seg;
    logic [N_DIGITS-1:0]      lane_dp;
    logic [N_DIGITS-1:0]      lz;
    logic [N_DIGITS-1:0]      onehot;

    assign tick = (cnt == CW'(SCAN_DIV - 1));
    assign last = (idx == IW'(N_DIGITS - 1));
    assign wrap = tick & last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= last ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A load landing on the wrap edge goes straight to the active copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_val    <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            act_val   <= '0;
            act_dp    <= '0;
            act_blank <= '0;
            pending   <= 1'b0;
        end else begin
            if (bus.load) begin
                sh_val   <= bus.value;
                sh_dp    <= bus.dp_in;
                sh_blank <= bus.blank_in;
            end
            if (wrap) begin
                if (bus.load) begin
                    act_val   <= bus.value;
                    act_dp    <= bus.dp_in;
                    act_blank <= bus.blank_in;
                end else if (pending) begin
                    act_val   <= sh_val;
                    act_dp    <= sh_dp;
                    act_blank <= sh_blank;
                end
                pending <= 1'b0;
            end else if (bus.load) begin
                pending <= 1'b1;
            end
        end
    end

`ifdef SEG_LZ_BLANK_EN
    logic [N_DIGITS:0] zero_up;
    assign zero_up[N_DIGITS] = 1'b1;
    for (genvar k = 0; k < N_DIGITS; k++) begin : g_lz
        assign zero_up[k] = zero_up[k+1] & (act_val[k] == 4'h0);
        assign lz[k]      = (k != 0) & zero_up[k];
    end
`else
    assign lz = '0;
`endif

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_lane
        seg7_digit_lane u_lane (
            .nib    (act_val[k]),
            .dp_bit (act_dp[k]),
            .blank  (act_blank[k]),
            .supp   (lz[k]),
            .seg    (lane_seg[k]),
            .dp     (lane_dp[k])
        );
    end

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.seg        <= SEG_OFF;
            bus.dp         <= SEG_ACTIVE_LOW;
            bus.an         <= AN_OFF;
            bus.frame_done <= 1'b0;
        end else begin
            bus.seg        <= lane_seg[idx] ^ SEG_OFF;
            bus.dp         <= lane_dp[idx] ^ SEG_ACTIVE_LOW;
            bus.an         <= onehot ^ AN_OFF;
            bus.frame_done <= wrap;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized + directed bench for seg7_scan_driver: active-high and active-low instances
// driven in parallel and compared to a frame-level display model.
module tb_seg7_scan_driver;
    localparam int N = 4;
    localparam int D = 4;

    logic        clk, rst;
    logic [15:0] value;
    logic [3:0]  dp_in, blank_in;
    logic        load;

    int checks, failures;

    seg7_scan_driver_if #(.N_DIGITS(N)) ifa ();
    seg7_scan_driver_if #(.N_DIGITS(N)) ifb ();

    assign ifa.value = value;  assign ifb.value = value;
    assign ifa.dp_in = dp_in;  assign ifb.dp_in = dp_in;
    assign ifa.blank_in = blank_in; assign ifb.blank_in = blank_in;
    assign ifa.load = load;    assign ifb.load = load;

    seg7_scan_driver #(.N_DIGITS(N), .SCAN_DIV(D), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0))
        dut (.clk(clk), .rst(rst), .bus(ifa));
    seg7_scan_driver #(.N_DIGITS(N), .SCAN_DIV(D), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1))
        dut_n (.clk(clk), .rst(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: edges since reset release, plus shadow/active display words.
    int          me;
    logic [15:0] m_sh, m_act;
    logic [3:0]  m_shdp, m_actdp, m_shbl, m_actbl;
    bit          m_pend;

    function automatic logic [6:0] dec(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[n];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        me = 0; m_pend = 0;
        m_sh = '0; m_shdp = '0; m_shbl = '0;
        m_act = '0; m_actdp = '0; m_actbl = '0;
    endtask

    task automatic chk_rst();
        chk("rst_seg",  {25'b0, ifa.seg}, 32'h00);
        chk("rst_dp",   {31'b0, ifa.dp}, 32'h0);
        chk("rst_an",   {28'b0, ifa.an}, 32'h0);
        chk("rst_fd",   {31'b0, ifa.frame_done}, 32'h0);
        chk("rst_seg_n",{25'b0, ifb.seg}, 32'h7F);
        chk("rst_dp_n", {31'b0, ifb.dp}, 32'h1);
        chk("rst_an_n", {28'b0, ifb.an}, 32'hF);
        chk("rst_fd_n", {31'b0, ifb.frame_done}, 32'h0);
    endtask

    // One clock: expected pins come from the pre-edge display state.
    task automatic cyc();
        int         mi;
        bit         supp, wrap;
        logic [6:0] es, ies;
        logic       edp;
        logic [3:0] ean, ian;
        mi   = (me / D) % N;
        ean  = 4'(1 << mi);
        supp = 0;
`ifdef SEG_LZ_BLANK_EN
        supp = (mi > 0) && ((m_act >> (4 * mi)) == 16'h0);
`endif
        es   = (m_actbl[mi] || supp) ? 7'h00 : dec(m_act[4*mi +: 4]);
        edp  = m_actbl[mi] ? 1'b0 : m_actdp[mi];
        wrap = (me % (D * N)) == (D * N - 1);
        @(posedge clk);
        if (load) begin
            m_sh = value; m_shdp = dp_in; m_shbl = blank_in; m_pend = 1;
        end
        if (wrap) begin
            if (m_pend) begin m_act = m_sh; m_actdp = m_shdp; m_actbl = m_shbl; end
            m_pend = 0;
        end
        me++;
        #1;
        ies = ~es; ian = ~ean;
        chk("seg",  {25'b0, ifa.seg}, {25'b0, es});
        chk("dp",   {31'b0, ifa.dp}, {31'b0, edp});
        chk("an",   {28'b0, ifa.an}, {28'b0, ean});
        chk("fd",   {31'b0, ifa.frame_done}, {31'b0, wrap});
        chk("seg_n",{25'b0, ifb.seg}, {25'b0, ies});
        chk("dp_n", {31'b0, ifb.dp}, {31'b0, ~edp});
        chk("an_n", {28'b0, ifb.an}, {28'b0, ian});
        chk("fd_n", {31'b0, ifb.frame_done}, {31'b0, wrap});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic ld(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value = v; dp_in = d; blank_in = b; load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_in = '0;
        mreset();
        #12;
        chk_rst();
        @(posedge clk); #1;
        rst = 1'b0;

        // Idle scan with zero word, then a mid-frame load
        run(20);
        ld(16'h1A2F, 4'b0000, 4'b0000);
        chk("pend_set", {31'b0, dut.pending}, {31'b0, m_pend});
        run(24);

        // Load exactly on the frame-wrap edge
        for (int i = 0; i < 16 && (me % 16) != 15; i++) cyc();
        ld(16'h8888, 4'b0000, 4'b0000);
        chk("pend_bypass", {31'b0, dut.pending}, 32'h0);
        run(16);

        // Decimal point and blanking
        ld(16'h3210, 4'b0100, 4'b0001);
        run(34);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            value    = 16'($urandom);
            dp_in    = 4'($urandom);
            blank_in = 4'($urandom);
            load     = ($urandom_range(0, 7) == 0);
            cyc();
            load = 1'b0;
        end

        // Reset mid-slot on digit 2 with a load pending
        for (int i = 0; i < 16 && (me % 16) != 0; i++) cyc();
        ld(16'h5555, 4'b1111, 4'b0000);
        for (int i = 0; i < 16 && (me % 16) != 9; i++) cyc();
        chk("pend_before_rst", {31'b0, dut.pending}, {31'b0, m_pend});
        #3;
        rst = 1'b1;
        #1;
        chk_rst();
        chk("pend_rst", {31'b0, dut.pending}, 32'h0);
        @(posedge clk); #1;
        chk_rst();
        rst = 1'b0;
        mreset();
        run(20);

        // Leading-zero patterns
        ld(16'h0042, 4'b0000, 4'b0000);
        run(36);
        ld(16'h0000, 4'b0000, 4'b0000);
        run(36);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed N-digit hexadecimal 7-segment display driver.
- Holds a double-buffered display word and scans one digit per refresh slot.
- Per digit: decodes the nibble to segments and drives the one-hot digit enable, with per-digit decimal point and blanking.
- Sits between board-level logic (counters, FSMs) and the display pins; replaces per-digit combinational decoders on multi-digit boards.

Parameters:
- N_DIGITS, 4, number of digits scanned (1..8).
- SCAN_DIV, 100000, clk cycles per digit slot (>=1).
- SEG_ACTIVE_LOW, 0, 1 inverts seg and dp at the pins.
- AN_ACTIVE_LOW, 0, 1 inverts an at the pins.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- value  in  4*N_DIGITS  hex digits; digit k = value[4k+3:4k]; digit 0 = rightmost.
- dp_in  in  N_DIGITS  decimal point request per digit.
- blank_in  in  N_DIGITS  1 = digit k dark (segments and dp off).
- load  in  1  capture value/dp_in/blank_in into the shadow buffer this edge.
- seg  out  7  segments, bit0=a .. bit6=g; registered.
- dp  out  1  decimal point; registered.
- an  out  N_DIGITS  one-hot digit enable; registered.
- frame_done  out  1  one-cycle pulse at frame wrap; registered.

Behaviour:
- Reset (async assert, all flops): prescaler cnt=0, idx=0, shadow=0, active=0, pending=0, frame_done=0. seg, dp and an are forced to the inactive pin level: 0, or all-ones when the matching *_ACTIVE_LOW=1.
- Prescaler: cnt counts 0..SCAN_DIV-1 and then wraps to 0. The wrap edge is a tick.
  - SCAN_DIV=1: a tick occurs every cycle.
- Digit index: on a tick, idx increments. When idx=N_DIGITS-1 it wraps to 0.
  - N_DIGITS=1: idx stays 0 and every tick is a frame wrap.
- Buffering:
  - load=1: shadow is overwritten and pending is set; the displayed digits do not change.
  - On a frame-wrap tick with pending=1: active is copied from shadow and pending is cleared.
  - If load and a frame-wrap tick occur on the same edge, the load data is bypassed straight into active, and pending ends 0.
  - Back-to-back loads: the last one before a wrap wins.
  - This prevents tearing mid-frame.
- Output pipeline: each cycle, the pins are registered from the current idx and active values. The pins lag idx by one cycle; seg, dp and an always change on the same edge.
  - an = one-hot(idx), then polarity applied.
  - If blank bit k is 1: seg=0 and dp=0 before polarity.
  - Otherwise: seg = decode(nibble k) and dp = dp bit k.
  - First cycle after reset release: an selects digit 0, seg=7'h3F.
- Decode table (active-high, g..a):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:67, A:77, b:7C, C:39, d:5E, E:79, F:71
- frame_done: 1 for exactly the one cycle after the tick edge where idx wraps N_DIGITS-1→0; 0 otherwise.
- Reset mid-scan: all state returns to reset values immediately (asynchronously), and any pending load is discarded.
- Synthesisable, no latches. The case decode is full, with a default of 00.

Optional Feature:
- Macro: SEG_LZ_BLANK_EN (leading-zero suppression).
- Defined: a digit k > 0 is also blanked when active digits k..N_DIGITS-1 are all 0. Digit 0 is never suppressed. dp still lights on a suppressed digit if its dp bit is 1 and its blank bit is 0.
  - Example: 0x0042 shows "  42"; 0x0000 shows "   0".
- Undefined: only blank_in controls darkness, so 0x0042 shows "0042".

Test Plan (N_DIGITS=4, SCAN_DIV=4, active-high unless noted):
- Reset, then release with value=0 and no load → an=0001, seg=3F one cycle later; an steps 0010, 0100, 1000 every 4 cycles; frame_done pulses once per 16 cycles.
- load with value=16'h1A2F mid-frame → no change until the next frame wrap; then digit0 seg=71, digit1 seg=5B, digit2 seg=77, digit3 seg=06.
- load on the exact frame-wrap edge with value=16'h8888 → the new frame shows 7F on all digits, and pending reads 0 after it.
- dp_in=4'b0100, blank_in=4'b0001 → digit2 seg=decode and dp=1; digit0 seg=00 and dp=0. Repeat with SEG_ACTIVE_LOW=1 and AN_ACTIVE_LOW=1 → all pins bitwise inverted, and reset pins are all-ones.
- Assert rst mid-slot on digit 2 with a load pending → pins go inactive immediately; after release the scan restarts at digit 0 showing 3F, and the pending data is discarded.
- With SEG_LZ_BLANK_EN and value=16'h0042 → digits 3 and 2 show 00, digit1 shows 66, digit0 shows 5B. With value=0, only digit0 shows 3F.
